// File: rtl/stopwatch_core.sv
// Stopwatch counting engine: min:sec with run/pause, field adjust and blink.
// Optional countdown support is enabled by defining STOPWATCH_COUNTDOWN_EN.
module stopwatch_core #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int BLINK_DIV = 25000000,
  parameter int MIN_MAX   = 99,
  parameter int MIN_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             adj,
  input  logic             sel,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic             down,
  output logic             expired,
`endif
  output logic [MIN_W-1:0] min,
  output logic [5:0]       sec,
  output logic             blink_min,
  output logic             blink_sec,
  output logic             running,
  output logic             rollover
);

  localparam int TW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
  localparam int AW = $clog2(ADJ_DIV > 1 ? ADJ_DIV : 2);
  localparam int BW = $clog2(BLINK_DIV > 1 ? BLINK_DIV : 2);

  localparam logic [TW-1:0]    TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0]    ADJ_LAST   = AW'(ADJ_DIV - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_LAST   = MIN_W'(MIN_MAX);

  typedef enum logic [1:0] {
    S_RUN,
    S_PAUSED,
    S_ADJ
  } state_t;

  state_t          state;
  logic            held;
  logic [TW-1:0]   tick_cnt;
  logic [AW-1:0]   adj_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            phase;

  logic            tick;
  logic            adj_tick;
  logic            sec_wrap;
  logic            min_wrap;
  logic [5:0]      sec_up;
  logic [MIN_W-1:0] min_up;
  logic            phase_n;

  assign tick     = (tick_cnt == TICK_LAST);
  assign adj_tick = (adj_cnt == ADJ_LAST);
  assign sec_wrap = (sec == 6'd59);
  assign min_wrap = (min == MIN_LAST);
  assign sec_up   = sec_wrap ? 6'd0 : sec + 6'd1;
  assign min_up   = min_wrap ? '0 : min + 1'b1;
  assign phase_n  = (blink_cnt == BLINK_LAST) ? ~phase : phase;

  // Mode control, prescalers, count and registered display qualifiers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_RUN;
      held      <= 1'b1;
      min       <= '0;
      sec       <= '0;
      tick_cnt  <= '0;
      adj_cnt   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
      rollover  <= 1'b0;
      running   <= 1'b1;
`ifdef STOPWATCH_COUNTDOWN_EN
      expired   <= 1'b0;
`endif
    end else begin
      rollover  <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
      if (state != S_ADJ && adj) begin
        state     <= S_ADJ;
        held      <= (state == S_RUN);
        running   <= 1'b0;
        adj_cnt   <= '0;
        blink_cnt <= '0;
        phase     <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
        expired   <= 1'b0;
`endif
      end else begin
        unique case (state)
          S_RUN: begin
            if (pause) begin
              state   <= S_PAUSED;
              running <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
              expired <= 1'b0;
`endif
            end else begin
              tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
              if (tick) begin
`ifdef STOPWATCH_COUNTDOWN_EN
                if (down) begin
                  if (sec != 6'd0 || min != '0) begin
                    if (sec == 6'd0) begin
                      sec <= 6'd59;
                      min <= min - 1'b1;
                    end else begin
                      sec <= sec - 6'd1;
                    end
                    if (min == '0 && sec == 6'd1) begin
                      state   <= S_PAUSED;
                      running <= 1'b0;
                      expired <= 1'b1;
                    end
                  end
                end else begin
`else
                begin
`endif
                  sec <= sec_up;
                  if (sec_wrap) begin
                    min      <= min_up;
                    rollover <= min_wrap;
                  end
                end
              end
            end
          end
          S_PAUSED: begin
            if (pause) begin
`ifdef STOPWATCH_COUNTDOWN_EN
              if (expired) begin
                expired <= 1'b0;
              end else begin
                state   <= S_RUN;
                running <= 1'b1;
              end
`else
              state   <= S_RUN;
              running <= 1'b1;
`endif
            end
          end
          default: begin
            if (!adj) begin
              state   <= held ? S_RUN : S_PAUSED;
              running <= held;
            end else begin
              if (pause) held <= ~held;
              adj_cnt <= adj_tick ? '0 : adj_cnt + 1'b1;
              if (adj_tick) begin
                if (sel) sec <= sec_up;
                else     min <= min_up;
              end
              blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
              phase     <= phase_n;
              blink_min <= phase_n & ~sel;
              blink_sec <= phase_n & sel;
            end
          end
        endcase
      end
    end
  end

endmodule
